divider_seq_param: RTL and testbench

Parametrised multi-cycle radix-2 restoring divider for the RICS datapath.
- Replaces the fixed 16-bit divider.
- Adds configurable operand width, a start/busy/done handshake and signed/unsigned mode per operation.
- Defines divide-by-zero and signed-overflow handling.
- Result packs the remainder (upper half) and the quotient (lower half) into one 2*WIDTH bus.

---
 rtl/divider_seq_param.sv | 140 ++++++++++++++
 tb/tb_divider_seq_param.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/divider_seq_param.sv
`default_nettype none
// ============================================================================
// Module      : divider_seq_param
// Description : Multi-cycle radix-2 restoring divider with a start/busy/done
//               handshake. Handles signed and unsigned operands,
//               divide-by-zero and signed overflow. The result bus carries
//               {remainder, quotient}.
// Revision    : 1.0 - initial release
// ============================================================================
module divider_seq_param #(
  parameter int WIDTH = 16
) (
  input  logic               inp_clk,
  input  logic               inp_rst_n,
  input  logic               inp_start,
  input  logic               inp_signed,
  input  logic [WIDTH-1:0]   inp_a,
  input  logic [WIDTH-1:0]   inp_b,
  output logic               out_busy,
  output logic               out_done,
  output logic               out_div_by_zero,
  output logic [2*WIDTH-1:0] out_result
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   rem_q;       // partial remainder, or raw dividend on divide-by-zero
  logic [WIDTH-1:0]   quo_q;       // dividend bits shifting out / quotient bits shifting in
  logic [WIDTH-1:0]   dvs_q;       // divisor magnitude; zero marks a divide-by-zero operation
  logic               sign_quo_q;
  logic               sign_rem_q;
  logic [CW-1:0]      cnt_q;
  logic               busy_q;
  logic               done_q;
  logic               dbz_q;
  logic [2*WIDTH-1:0] result_q;

  logic [WIDTH-1:0]   a_abs_d;
  logic [WIDTH-1:0]   b_abs_d;
  logic [WIDTH:0]     shifted_d;
  logic [WIDTH:0]     trial_d;
  logic [WIDTH-1:0]   rem_d;
  logic [WIDTH-1:0]   quo_d;
  logic [WIDTH-1:0]   quo_fix_d;
  logic [WIDTH-1:0]   rem_fix_d;
  logic               accept_d;

  // Operand magnitudes, one restoring step, and the final sign correction
  always_comb begin
    a_abs_d   = (inp_signed && inp_a[WIDTH-1]) ? -inp_a : inp_a;
    b_abs_d   = (inp_signed && inp_b[WIDTH-1]) ? -inp_b : inp_b;
    // Remainder is always below the divisor, so the shifted value fits in WIDTH+1 bits
    shifted_d = {rem_q, quo_q[WIDTH-1]};
    trial_d   = shifted_d - {1'b0, dvs_q};
    if (!trial_d[WIDTH]) begin
      rem_d = trial_d[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_d = shifted_d[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], 1'b0};
    end
    quo_fix_d = sign_quo_q ? -quo_q : quo_q;
    rem_fix_d = sign_rem_q ? -rem_q : rem_q;
    accept_d  = inp_start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  end

  // Control FSM with datapath registers and registered handshake outputs
  always_ff @(posedge inp_clk or negedge inp_rst_n) begin
    if (!inp_rst_n) begin
      state_q    <= ST_IDLE;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      sign_quo_q <= 1'b0;
      sign_rem_q <= 1'b0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dbz_q      <= 1'b0;
      result_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (accept_d) begin
            // Divide-by-zero keeps the untouched dividend for the remainder field
            rem_q      <= (inp_b == '0) ? inp_a : '0;
            quo_q      <= a_abs_d;
            dvs_q      <= b_abs_d;
            sign_quo_q <= inp_signed & (inp_a[WIDTH-1] ^ inp_b[WIDTH-1]);
            sign_rem_q <= inp_signed & inp_a[WIDTH-1];
            dbz_q      <= 1'b0;
            busy_q     <= 1'b1;
            cnt_q      <= CW'(WIDTH);
            state_q    <= (inp_b == '0) ? ST_FIX : ST_CALC;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_CALC: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q <= ST_FIX;
          end
        end
        ST_FIX: begin
          if (dvs_q == '0) begin
            result_q <= {rem_q, {WIDTH{1'b1}}};
            dbz_q    <= 1'b1;
          end else begin
            result_q <= {rem_fix_d, quo_fix_d};
          end
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_DONE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign out_busy        = busy_q;
  assign out_done        = done_q;
  assign out_div_by_zero = dbz_q;
  assign out_result      = result_q;

endmodule
`default_nettype wire

// File: tb/tb_divider_seq_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_divider_seq_param
// Description : Self-checking bench for divider_seq_param (WIDTH=16 and 8)
//               against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_divider_seq_param;

  logic        clk;
  logic        rst_n;
  logic        start16, sgn16;
  logic [15:0] a16, b16;
  logic        busy16, done16, dbz16;
  logic [31:0] res16;
  logic        start8, sgn8;
  logic [7:0]  a8, b8;
  logic        busy8, done8, dbz8;
  logic [15:0] res8;

  int checks = 0;
  int errors = 0;
  int ncyc   = 0;

  typedef struct {
    int          due;
    logic [31:0] res;
    bit          dz;
  } exp_t;
  exp_t q16[$];

  divider_seq_param #(.WIDTH(16)) dut16 (
    .inp_clk(clk), .inp_rst_n(rst_n), .inp_start(start16), .inp_signed(sgn16),
    .inp_a(a16), .inp_b(b16), .out_busy(busy16), .out_done(done16),
    .out_div_by_zero(dbz16), .out_result(res16)
  );

  divider_seq_param #(.WIDTH(8)) dut8 (
    .inp_clk(clk), .inp_rst_n(rst_n), .inp_start(start8), .inp_signed(sgn8),
    .inp_a(a8), .inp_b(b8), .out_busy(busy8), .out_done(done8),
    .out_div_by_zero(dbz8), .out_result(res8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer division, truncation toward zero, remainder
  // signed like the dividend; divisor 0 gives {a, all ones}.
  function automatic logic [63:0] model(input int w, input bit sgn,
                                        input longint a, input longint b);
    longint one = 1;
    longint m   = (one << w) - 1;
    longint sa, sb, q, r;
    if (b == 0) return ((a & m) << w) | m;
    if (sgn) begin
      sa = (a >= (one << (w - 1))) ? a - (one << w) : a;
      sb = (b >= (one << (w - 1))) ? b - (one << w) : b;
      q  = sa / sb;
      r  = sa % sb;
    end else begin
      q = a / b;
      r = a % b;
    end
    return ((r & m) << w) | (q & m);
  endfunction

  // Per-cycle compare of the 16-bit instance against the expectation queue
  initial begin
    exp_t        e;
    logic [31:0] last_res = '0;
    bit          last_dz  = 1'b0;
    forever begin
      @(negedge clk);
      ncyc++;
      if (!rst_n) begin
        q16.delete();
        last_res = '0;
        last_dz  = 1'b0;
        chk("rst_busy",   64'(busy16), 64'(0));
        chk("rst_done",   64'(done16), 64'(0));
        chk("rst_dbz",    64'(dbz16),  64'(0));
        chk("rst_result", 64'(res16),  64'(0));
      end else if (done16) begin
        chk("done_busy", 64'(busy16), 64'(0));
        if (q16.size() == 0) begin
          chk("unexpected_done", 64'(done16), 64'(0));
        end else begin
          e = q16.pop_front();
          chk("done_cycle", 64'(ncyc),   64'(e.due));
          chk("result",     64'(res16),  64'(e.res));
          chk("div_by_zero",64'(dbz16),  64'(e.dz));
          last_res = e.res;
          last_dz  = e.dz;
        end
      end else begin
        chk("busy",        64'(busy16), 64'(q16.size() != 0));
        chk("result_hold", 64'(res16),  64'(last_res));
        chk("dbz_hold",    64'(dbz16),  64'((q16.size() != 0) ? 1'b0 : last_dz));
        if (q16.size() != 0 && ncyc > q16[0].due) begin
          chk("done_timeout", 64'(ncyc), 64'(q16[0].due));
          void'(q16.pop_front());
        end
      end
    end
  end

  // Called at a falling edge; returns at the falling edge where done is seen
  task automatic run16(input bit sgn, input logic [15:0] a, input logic [15:0] b,
                       input logic [31:0] exp);
    #1;
    sgn16 = sgn; a16 = a; b16 = b; start16 = 1'b1;
    q16.push_back('{due: ncyc + ((b == 16'd0) ? 2 : 18), res: exp, dz: (b == 16'd0)});
    @(negedge clk);
    start16 = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done16) break;
      @(negedge clk);
    end
  endtask

  task automatic run8(input bit sgn, input logic [7:0] a, input logic [7:0] b,
                      input logic [15:0] exp);
    int n = 0;
    #1;
    sgn8 = sgn; a8 = a; b8 = b; start8 = 1'b1;
    @(negedge clk);
    n = 1;
    start8 = 1'b0;
    while (!done8 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("w8_latency", 64'(n),    64'((b == 8'd0) ? 2 : 10));
    chk("w8_result",  64'(res8), 64'(exp));
    chk("w8_dbz",     64'(dbz8), 64'(b == 8'd0));
  endtask

  initial begin
    logic [15:0] ra, rb;
    logic [7:0]  ra8, rb8;
    bit          rs;
    rst_n = 1'b0; start16 = 1'b0; sgn16 = 1'b0; a16 = '0; b16 = '0;
    start8 = 1'b0; sgn8 = 1'b0; a8 = '0; b8 = '0;

    // Hand-computed values pinning the reference model
    chk("model_u_30576_16", model(16, 0, 30576, 16),        64'h0000_0777);
    chk("model_s_m99_7",    model(16, 1, 16'hFF9D, 7),      64'hFFFF_FFF2);
    chk("model_s_99_m7",    model(16, 1, 99, 16'hFFF9),     64'h0001_FFF2);
    chk("model_s_ovf",      model(16, 1, 16'h8000, 16'hFFFF), 64'h0000_8000);
    chk("model_div0",       model(16, 0, 1234, 0),          64'h04D2_FFFF);
    chk("model_w8_200_3",   model(8, 0, 200, 3),            64'h0242);

    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);

    // Directed cases with literal expectations
    run16(0, 16'd30576, 16'd16, 32'h0000_0777);
    @(negedge clk);
    run16(0, 16'd30578, 16'd16, 32'h0002_0777);
    run16(0, 16'd99,    16'd7,  32'h0001_000E);   // started in the DONE cycle
    @(negedge clk);
    run16(1, 16'hFF9D, 16'd7,    32'hFFFF_FFF2);
    run16(1, 16'd99,   16'hFFF9, 32'h0001_FFF2);
    run16(1, 16'h8000, 16'hFFFF, 32'h0000_8000);
    run16(0, 16'd1234, 16'd0,    32'h04D2_FFFF);
    repeat (2) @(negedge clk);
    run16(0, 16'd100,  16'd10,   32'h0000_000A);  // clears the divide-by-zero flag

    // Ignored start while busy, then reset mid-operation
    @(negedge clk);
    #1 sgn16 = 1'b0; a16 = 16'd99; b16 = 16'd7; start16 = 1'b1;
    q16.push_back('{due: ncyc + 18, res: 32'h0001_000E, dz: 1'b0});
    @(negedge clk);
    start16 = 1'b0;
    repeat (3) @(negedge clk);
    #1 a16 = 16'd5000; b16 = 16'd3; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_busy",   64'(busy16), 64'(0));
    chk("async_rst_result", 64'(res16),  64'(0));
    chk("async_rst_done",   64'(done16), 64'(0));
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (25) @(negedge clk);
    run16(0, 16'd99, 16'd7, 32'h0001_000E);

    // Randomized operations, including corner operands and back-to-back starts
    for (int i = 0; i < 200; i++) begin
      rs = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 9))
        0:       rb = 16'd0;
        1:       rb = 16'hFFFF;
        2:       rb = 16'($urandom_range(1, 7));
        default: rb = 16'($urandom);
      endcase
      ra = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
      run16(rs, ra, rb, 32'(model(16, rs, longint'(ra), longint'(rb))));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Narrow instance
    @(negedge clk);
    run8(0, 8'd200, 8'd3,  16'h0242);
    @(negedge clk);
    run8(1, 8'h80,  8'hFF, 16'h0080);
    @(negedge clk);
    run8(0, 8'd77,  8'd0,  16'h4DFF);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      rs  = 1'($urandom_range(0, 1));
      ra8 = 8'($urandom);
      rb8 = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
      run8(rs, ra8, rb8, 16'(model(8, rs, longint'(ra8), longint'(rb8))));
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", 64'(q16.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
